reg_bus_arbiter: RTL and testbench
==================================

# reg_bus_arbiter

Two-requester arbiter and sequencer for the 8-bit register bus of the pulse-generator register bank. It grants one requester at a time, round-robin, so the host command port and the on-chip sequencer can both reach the bank. Granted accesses are issued as single-cycle write or read strobes, and the bank's registered read data is captured and returned with a one-cycle acknowledge. It sits between the requesters and the bank's i_wr / i_addr / i_data / o_data port.

## Interface
- ADDR_W, 7, register address width
- DATA_W, 8, register data width
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset (clears immediately, release synchronous to i_clk)
- i_a_req  in  1  requester A request level; i_a_wr/i_a_addr/i_a_wdata stable while high and not yet acked
- i_a_wr  in  1  1 = write, 0 = read
- i_a_addr  in  ADDR_W  register address
- i_a_wdata  in  DATA_W  write data
- o_a_ack  out  1  one-cycle pulse, transaction complete
- o_a_rdata  out  DATA_W  read data, updated only on A read completion, held otherwise
- i_b_req, i_b_wr, i_b_addr, i_b_wdata, o_b_ack, o_b_rdata: requester B, identical to A
- o_wr  out  1  bank write strobe
- o_addr  out  ADDR_W  bank address
- o_data  out  DATA_W  bank write data
- i_data  in  DATA_W  bank read data, registered in bank, valid one cycle after address presented
- o_busy  out  1  high in any state other than IDLE
- o_grant  out  1  current/last grantee, 0 = A, 1 = B

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: if any request is high, pick winner, latch its wr/addr/wdata into o_wr/o_addr/o_data, set o_grant, go to ISSUE. Otherwise stay, with o_wr = 0 and o_addr/o_data holding last values.
- Arbitration:
  - Single request: granted.
  - Both high: grant the requester other than last grantee.
  - Last-grantee pointer updates at grant; reset value = B, so A wins the first tie.
- ISSUE: strobe presented for exactly one cycle; bank writes or loads read data at the end of it. Go to CAPTURE.
- CAPTURE: force o_wr to 0. On the closing edge:
  - if the grantee's access was a read, load its rdata from i_data;
  - assert its ack;
  - go to DONE.
- DONE: ack high for this cycle only; requests ignored. Go to IDLE, ack cleared.
- Writes never modify rdata. The other requester's outputs are untouched.
- Requester rules:
  - Hold req and fields until ack is seen.
  - req high in a later IDLE is a new transaction.
  - Changing fields in the cycle after ack is legal.
  - Dropping req before ack is illegal (behaviour undefined).
- Unmapped addresses are not checked; the bank returns 0x00 on reads.
- Reset values: state IDLE, o_wr 0, o_addr 0, o_data 0, o_a_ack/o_b_ack 0, o_a_rdata/o_b_rdata 0, o_busy 0, o_grant 1 (B = last).
- Reset mid-operation: all outputs return to reset values asynchronously, and the in-flight transaction is abandoned with no ack. The requester re-issues after release.

## Timing
- E0 = edge at which IDLE samples a request.
- E0..E1: o_wr/o_addr/o_data valid, o_busy 1.
- E1: bank samples the strobe.
- E1..E2: i_data valid for reads.
- E2: rdata captured, ack set.
- E2..E3: ack high.
- E3: back to IDLE.
- E4: earliest next grant sample.
- Throughput: one transaction per 4 cycles. Back-to-back grants from continuous requests are 4 cycles apart.
- All outputs are registered; no combinational path from requester inputs to outputs.

## Test plan
- Reset: drive i_rst_n low mid-clock -> all outputs 0 and o_grant 1 without waiting for an edge.
- A write 0x10 <= 0xA5 sampled at E0 -> o_wr=1, o_addr=0x10, o_data=0xA5 only during E0..E1; o_a_ack high E2..E3; o_a_rdata stays 0x00.
- Then B read 0x10 -> o_b_rdata=0xA5 with o_b_ack pulse; o_a_rdata unchanged.
- Simultaneous A and B requests right after reset -> A granted first, o_grant=0, A ack at E2. B granted at E4, B ack at E6.
- Both req held high continuously for 8 transactions -> grants alternate A,B,A,B…; each ack exactly 4 cycles after the previous one; no double grant in DONE.
- B read of unmapped address 0x05 -> o_b_rdata=0x00, ack issued normally.
- i_rst_n asserted during ISSUE of an A write -> o_wr drops immediately, no A ack. After release, A still requesting is re-granted and completes; the register reads back the written value.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter for two requesters sharing the pulse-generator register bus.
// Each grant runs a fixed four-cycle sequence: issue strobe, capture read data, ack, back to idle.
module reg_bus_arbiter #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_req,
  input  logic              i_a_wr,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_ack,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_req,
  input  logic              i_b_wr,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_ack,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_grant
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                grant_q, grant_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                pick_b;

  // On a tie the requester that was not granted last wins; grant_q doubles as that pointer.
  assign pick_b = i_b_req & (~i_a_req | ~grant_q);

  always_comb begin
    state_d   = state_q;
    wr_d      = 1'b0;
    rd_d      = rd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    grant_d   = grant_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      StIdle: begin
        if (i_a_req || i_b_req) begin
          grant_d = pick_b;
          wr_d    = pick_b ? i_b_wr : i_a_wr;
          rd_d    = pick_b ? ~i_b_wr : ~i_a_wr;
          addr_d  = pick_b ? i_b_addr : i_a_addr;
          data_d  = pick_b ? i_b_wdata : i_a_wdata;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        // rd_q is kept separately because o_wr is already low here.
        if (rd_q) begin
          if (grant_q) b_rdata_d = i_data;
          else         a_rdata_d = i_data;
        end
        a_ack_d = ~grant_q;
        b_ack_d = grant_q;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      grant_q   <= 1'b1;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign o_wr      = wr_q;
  assign o_addr    = addr_q;
  assign o_data    = data_q;
  assign o_grant   = grant_q;
  assign o_a_ack   = a_ack_q;
  assign o_b_ack   = b_ack_q;
  assign o_a_rdata = a_rdata_q;
  assign o_b_rdata = b_rdata_q;
  assign o_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with a small register-bank model on the bus side.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_bus_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       a_req, a_wr, b_req, b_wr;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       o_a_ack, o_b_ack, o_wr, o_busy, o_grant;
  logic [7:0] o_a_rdata, o_b_rdata, o_data;
  logic [6:0] o_addr;
  logic [7:0] i_data;

  int checks = 0;
  int errors = 0;

  // {busy, grant, wr, addr, data}
  wire [17:0] bus  = {o_busy, o_grant, o_wr, o_addr, o_data};
  wire [1:0]  acks = {o_a_ack, o_b_ack};
  wire [35:0] all_out = {bus, acks, o_a_rdata, o_b_rdata};
  localparam logic [35:0] RstOut = {1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 2'b00, 8'h00, 8'h00};

  reg_bus_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_a_req(a_req), .i_a_wr(a_wr), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_ack(o_a_ack), .o_a_rdata(o_a_rdata),
    .i_b_req(b_req), .i_b_wr(b_wr), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(o_b_ack), .o_b_rdata(o_b_rdata),
    .o_wr(o_wr), .o_addr(o_addr), .o_data(o_data), .i_data(i_data),
    .o_busy(o_busy), .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  // Bank: 0x10..0x1F mapped, everything else reads 0x00; read data registered.
  logic [7:0] mem [0:127];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    i_data = 8'h00;
  end
  always @(posedge i_clk) begin
    if (o_wr && o_addr[6:4] == 3'b001) mem[o_addr] <= o_data;
    i_data <= (o_addr[6:4] == 3'b001) ? mem[o_addr] : 8'h00;
  end

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== RstOut) begin
      errors++; $display("FAIL reset_async got %h want %h", all_out, RstOut);
    end
    @(negedge i_clk);
    checks++;
    if (all_out !== RstOut) begin
      errors++; $display("FAIL reset_hold got %h want %h", all_out, RstOut);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (all_out !== RstOut) begin
      errors++; $display("FAIL reset_idle got %h want %h", all_out, RstOut);
    end
  endtask

  task automatic test_tie_after_reset();
    a_req = 1; a_wr = 1; a_addr = 7'h11; a_wdata = 8'h3C;
    b_req = 1; b_wr = 0; b_addr = 7'h11; b_wdata = 8'hFF;
    @(negedge i_clk);
    checks++;
    if (bus !== {1'b1, 1'b0, 1'b1, 7'h11, 8'h3C}) begin
      errors++; $display("FAIL tie_a_issue got %h want %h", bus, {1'b1, 1'b0, 1'b1, 7'h11, 8'h3C});
    end
    @(negedge i_clk);
    checks++;
    if ({bus, acks} !== {1'b1, 1'b0, 1'b0, 7'h11, 8'h3C, 2'b00}) begin
      errors++; $display("FAIL tie_a_capture got %h want %h", {bus, acks},
                         {1'b1, 1'b0, 1'b0, 7'h11, 8'h3C, 2'b00});
    end
    @(negedge i_clk);
    checks++;
    if (acks !== 2'b10) begin
      errors++; $display("FAIL tie_a_ack got %b want 10", acks);
    end
    a_req = 0;
    @(negedge i_clk);
    checks++;
    if ({bus, acks} !== {1'b0, 1'b0, 1'b0, 7'h11, 8'h3C, 2'b00}) begin
      errors++; $display("FAIL tie_idle got %h want %h", {bus, acks},
                         {1'b0, 1'b0, 1'b0, 7'h11, 8'h3C, 2'b00});
    end
    @(negedge i_clk);
    checks++;
    if (bus !== {1'b1, 1'b1, 1'b0, 7'h11, 8'hFF}) begin
      errors++; $display("FAIL tie_b_issue got %h want %h", bus, {1'b1, 1'b1, 1'b0, 7'h11, 8'hFF});
    end
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({acks, o_b_rdata, o_a_rdata} !== {2'b01, 8'h3C, 8'h00}) begin
      errors++; $display("FAIL tie_b_ack got %h want %h", {acks, o_b_rdata, o_a_rdata},
                         {2'b01, 8'h3C, 8'h00});
    end
    b_req = 0;
    @(negedge i_clk);
    checks++;
    if ({o_busy, acks} !== 3'b000) begin
      errors++; $display("FAIL tie_end got %b want 000", {o_busy, acks});
    end
  endtask

  task automatic test_write_read();
    a_req = 1; a_wr = 1; a_addr = 7'h10; a_wdata = 8'hA5;
    @(negedge i_clk);
    checks++;
    if (bus !== {1'b1, 1'b0, 1'b1, 7'h10, 8'hA5}) begin
      errors++; $display("FAIL wr_issue got %h want %h", bus, {1'b1, 1'b0, 1'b1, 7'h10, 8'hA5});
    end
    @(negedge i_clk);
    checks++;
    if ({o_wr, acks} !== 3'b000) begin
      errors++; $display("FAIL wr_strobe_len got %b want 000", {o_wr, acks});
    end
    @(negedge i_clk);
    checks++;
    if ({acks, o_a_rdata} !== {2'b10, 8'h00}) begin
      errors++; $display("FAIL wr_ack got %h want %h", {acks, o_a_rdata}, {2'b10, 8'h00});
    end
    a_req = 0;
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_wr, acks} !== 4'b0000) begin
      errors++; $display("FAIL wr_end got %b want 0000", {o_busy, o_wr, acks});
    end
    b_req = 1; b_wr = 0; b_addr = 7'h10; b_wdata = 8'h77;
    @(negedge i_clk);
    checks++;
    if (bus !== {1'b1, 1'b1, 1'b0, 7'h10, 8'h77}) begin
      errors++; $display("FAIL rd_issue got %h want %h", bus, {1'b1, 1'b1, 1'b0, 7'h10, 8'h77});
    end
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({acks, o_b_rdata, o_a_rdata} !== {2'b01, 8'hA5, 8'h00}) begin
      errors++; $display("FAIL rd_ack got %h want %h", {acks, o_b_rdata, o_a_rdata},
                         {2'b01, 8'hA5, 8'h00});
    end
    b_req = 0;
    @(negedge i_clk);
  endtask

  task automatic test_unmapped();
    b_req = 1; b_wr = 0; b_addr = 7'h05; b_wdata = 8'h00;
    @(negedge i_clk);
    checks++;
    if (bus !== {1'b1, 1'b1, 1'b0, 7'h05, 8'h00}) begin
      errors++; $display("FAIL unm_issue got %h want %h", bus, {1'b1, 1'b1, 1'b0, 7'h05, 8'h00});
    end
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({acks, o_b_rdata} !== {2'b01, 8'h00}) begin
      errors++; $display("FAIL unm_ack got %h want %h", {acks, o_b_rdata}, {2'b01, 8'h00});
    end
    b_req = 0;
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back();
    logic g;
    a_req = 1; a_wr = 1; a_addr = 7'h13; a_wdata = 8'h5A;
    b_req = 1; b_wr = 0; b_addr = 7'h13; b_wdata = 8'h99;
    for (int t = 0; t < 8; t++) begin
      g = (t % 2 == 1);
      @(negedge i_clk);
      checks++;
      if (bus !== {1'b1, g, ~g, 7'h13, (g ? 8'h99 : 8'h5A)}) begin
        errors++; $display("FAIL b2b_issue t=%0d got %h want %h", t, bus,
                           {1'b1, g, ~g, 7'h13, (g ? 8'h99 : 8'h5A)});
      end
      @(negedge i_clk);
      checks++;
      if (acks !== 2'b00) begin
        errors++; $display("FAIL b2b_early_ack t=%0d got %b want 00", t, acks);
      end
      @(negedge i_clk);
      checks++;
      if ({acks, o_b_rdata} !== {(g ? 2'b01 : 2'b10), (t == 0 ? 8'h00 : 8'h5A)}) begin
        errors++; $display("FAIL b2b_ack t=%0d got %h want %h", t, {acks, o_b_rdata},
                           {(g ? 2'b01 : 2'b10), (t == 0 ? 8'h00 : 8'h5A)});
      end
      @(negedge i_clk);
      checks++;
      if ({o_busy, acks} !== 3'b000) begin
        errors++; $display("FAIL b2b_idle t=%0d got %b want 000", t, {o_busy, acks});
      end
    end
    a_req = 0; b_req = 0;
  endtask

  task automatic test_reset_mid_issue();
    a_req = 1; a_wr = 1; a_addr = 7'h14; a_wdata = 8'hC3;
    @(negedge i_clk);
    checks++;
    if (bus !== {1'b1, 1'b0, 1'b1, 7'h14, 8'hC3}) begin
      errors++; $display("FAIL mid_issue got %h want %h", bus, {1'b1, 1'b0, 1'b1, 7'h14, 8'hC3});
    end
    #1 i_rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== RstOut) begin
      errors++; $display("FAIL mid_reset got %h want %h", all_out, RstOut);
    end
    @(negedge i_clk);
    checks++;
    if ({acks, mem[7'h14]} !== {2'b00, 8'h00}) begin
      errors++; $display("FAIL mid_no_ack got %h want %h", {acks, mem[7'h14]}, {2'b00, 8'h00});
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus !== {1'b1, 1'b0, 1'b1, 7'h14, 8'hC3}) begin
      errors++; $display("FAIL mid_regrant got %h want %h", bus, {1'b1, 1'b0, 1'b1, 7'h14, 8'hC3});
    end
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (acks !== 2'b10) begin
      errors++; $display("FAIL mid_ack got %b want 10", acks);
    end
    a_req = 0;
    @(negedge i_clk);
    b_req = 1; b_wr = 0; b_addr = 7'h14; b_wdata = 8'h00;
    @(negedge i_clk);
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({acks, o_b_rdata} !== {2'b01, 8'hC3}) begin
      errors++; $display("FAIL mid_readback got %h want %h", {acks, o_b_rdata}, {2'b01, 8'hC3});
    end
    b_req = 0;
    @(negedge i_clk);
    checks++;
    if ({o_busy, acks} !== 3'b000) begin
      errors++; $display("FAIL mid_end got %b want 000", {o_busy, acks});
    end
  endtask

  initial begin
    i_rst_n = 1'b1;
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_tie_after_reset();
    test_write_read();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
